// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: byte-wide RAM/IO bus plus the fetch and load/store
// request channels. master = arbiter side, slave = requesters and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_data;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ready;
    logic [31:0]       ls_rdata;

    modport master (
        input  mem_din, io_buffer_full,
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output mem_dout, mem_a, mem_wr,
        output if_ready, if_data,
        output ls_ready, ls_rdata
    );

    modport slave (
        output mem_din, io_buffer_full,
        output if_req, if_addr,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  if_ready, if_data,
        input  ls_ready, ls_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM/IO bus between instruction fetch and load/store, one byte per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate tie grants instead of fixed load/store priority.
//
// state   | meaning
// IDLE    | no transfer in flight; grant is decided in this cycle
// IF_RD   | fetch read: byte addresses out, then one final capture cycle
// LS_RD   | load read: same timing as IF_RD, length from ls_size
// LS_WR   | store: one byte per cycle, IO bytes held off while io_buffer_full
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    input logic         clr,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IF_RD = 2'd1;
    localparam logic [1:0] S_LS_RD = 2'd2;
    localparam logic [1:0] S_LS_WR = 2'd3;

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [2:0]        cnt_p1;
    logic [2:0]        ls_len;
    logic [1:0]        cap_lane;
    logic [1:0]        nxt_lane;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] nxt_addr;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rd_word;

    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic              if_ready_q;
    logic [31:0]       if_data_q;
    logic              ls_ready_q;
    logic [31:0]       ls_rdata_q;

    logic              if_elig;
    logic              ls_elig;
    logic              pick_ls;
    logic              pick_if;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_ls;
`endif

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_SEL;
    endfunction

    always_comb begin
        cnt_p1   = cnt + 3'd1;
        cap_lane = cnt[1:0] - 2'd1;
        nxt_lane = cnt_p1[1:0];
        nxt_addr = base + ADDR_W'(cnt_p1);

        // byte arriving this cycle belongs to the address issued one cycle earlier
        rd_word = rbuf;
        rd_word[{cap_lane, 3'b000} +: 8] = bus.mem_din;

        case (bus.ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase

        // a port whose ready pulse is out right now is not granted again
        if_elig = bus.if_req & ~clr & ~if_ready_q;
        ls_elig = bus.ls_req & ~ls_ready_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_ls = ls_elig & (~if_elig | ~last_ls);
`else
        pick_ls = ls_elig;
`endif
        pick_if = if_elig & ~pick_ls;
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls <= 1'b0;
        end else if (rdy && state == S_IDLE && (pick_ls || pick_if)) begin
            last_ls <= pick_ls;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            len        <= 3'd0;
            base       <= '0;
            wdata      <= 32'd0;
            rbuf       <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_ready_q <= 1'b0;
            if_data_q  <= 32'd0;
            ls_ready_q <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else if (rdy) begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_wr_q <= 1'b0;
                    if (pick_ls) begin
                        state      <= bus.ls_we ? S_LS_WR : S_LS_RD;
                        cnt        <= 3'd0;
                        len        <= ls_len;
                        base       <= bus.ls_addr;
                        wdata      <= bus.ls_wdata;
                        rbuf       <= 32'd0;
                        mem_a_q    <= bus.ls_addr;
                        mem_dout_q <= bus.ls_wdata[7:0];
                        mem_wr_q   <= bus.ls_we & ~(is_io(bus.ls_addr) & bus.io_buffer_full);
                    end else if (pick_if) begin
                        state   <= S_IF_RD;
                        cnt     <= 3'd0;
                        len     <= 3'd4;
                        base    <= bus.if_addr;
                        rbuf    <= 32'd0;
                        mem_a_q <= bus.if_addr;
                    end
                end

                S_IF_RD, S_LS_RD: begin
                    if (state == S_IF_RD && clr) begin
                        state <= S_IDLE;
                    end else begin
                        if (cnt != 3'd0) begin
                            rbuf <= rd_word;
                        end
                        if (cnt == len) begin
                            state <= S_IDLE;
                            if (state == S_IF_RD) begin
                                if_ready_q <= 1'b1;
                                if_data_q  <= rd_word;
                            end else begin
                                ls_ready_q <= 1'b1;
                                ls_rdata_q <= rd_word;
                            end
                        end else begin
                            cnt <= cnt_p1;
                            if (cnt_p1 < len) begin
                                mem_a_q <= nxt_addr;
                            end
                        end
                    end
                end

                S_LS_WR: begin
                    if (mem_wr_q) begin
                        if (cnt == len - 3'd1) begin
                            state      <= S_IDLE;
                            mem_wr_q   <= 1'b0;
                            ls_ready_q <= 1'b1;
                        end else begin
                            cnt        <= cnt_p1;
                            mem_a_q    <= nxt_addr;
                            mem_dout_q <= wdata[{nxt_lane, 3'b000} +: 8];
                            mem_wr_q   <= ~(is_io(nxt_addr) & bus.io_buffer_full);
                        end
                    end else begin
                        // stalled byte: issue decision uses the flag seen this cycle
                        mem_wr_q <= ~(is_io(mem_a_q) & bus.io_buffer_full);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.if_ready = if_ready_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_ready = ls_ready_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Byte-serial memory controller that shares the single 8-bit RAM/IO bus between the instruction-fetch path and the load/store path. It grants one requester at a time and serializes each 1/2/4-byte access into per-byte bus cycles. Read bytes are assembled little-endian into a word. Writes to IO addresses are throttled on io_buffer_full, and in-flight fetches are aborted on pipeline clear.

Parameters:
ADDR_W, 32, width of all address ports and mem_a
IO_SEL, 2'b11, value of addr[17:16] that marks an IO access

Ports:
clk  in  1  system clock (posedge)
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low every register holds
clr  in  1  pipeline flush; aborts fetch transfers
mem_din  in  8  read data, valid the cycle after its address
mem_dout  out  8  write data byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  UART tx buffer full
if_req  in  1  fetch request, level, held until if_ready
if_addr  in  32  fetch word address
if_ready  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
ls_req  in  1  load/store request, level, held until ls_ready
ls_we  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 or 3 = word
ls_addr  in  32  byte address
ls_wdata  in  32  store data, low bytes used
ls_ready  out  1  one-cycle pulse, access complete
ls_rdata  out  32  load data, zero-extended

Behaviour:
- Reset values:
  - All outputs (mem_a, mem_dout, mem_wr, if_ready, if_data, ls_ready, ls_rdata) are 0.
  - FSM is in IDLE; byte counter is 0.
- FSM states: IDLE, IF_RD, LS_RD, LS_WR.
- Transfer length N: 4 for fetches; 1/2/4 for loads/stores per ls_size.
- Grant (IDLE, cycle T):
  - ls_req and if_req are both eligible; ls wins ties (fixed priority).
  - The IF grant is blocked during any cycle with clr=1.
  - Request fields are latched at grant.
- Read timing:
  - Byte k address (base+k) is on mem_a during cycle T+1+k, with mem_wr=0.
  - The matching mem_din is captured at the end of cycle T+2+k into bits [8k+7:8k].
  - ready and data are high during cycle T+2+N only. A word fetch pulses if_ready at T+6.
  - Unused high bytes of ls_rdata are 0.
- Write timing:
  - Byte k is driven during cycle T+1+k, with mem_wr=1, mem_a=base+k and mem_dout=wdata[8k+7:8k].
  - ls_ready pulses at T+1+N.
- Between transfers (IDLE): mem_wr=0; mem_a holds its last value.
- IO throttle:
  - Applies to an LS_WR byte whose address has [17:16]==IO_SEL.
  - While io_buffer_full=1, the byte is not issued: mem_wr=0 and the counter holds.
  - Issue resumes the cycle after the flag drops.
- IO reads are never reissued. Each byte address is driven exactly once per transfer, so 0x30000 is consumed once.
- The ready cycle returns the FSM to IDLE, and a new grant may occur in that same cycle. The port just served is masked out of that grant, so a requester may drop req in the cycle after its ready pulse without getting a duplicate transfer.
- clr behaviour:
  - clr during IF_RD: go to IDLE next cycle; no if_ready; partial data is discarded. The next fetch restarts from byte 0.
  - clr does not affect LS_RD or LS_WR; these always complete.
- Simultaneous events:
  - clr in the same cycle as the if_ready pulse: the pulse is still emitted. The consumer filters it.
  - rst overrides all other inputs, including mid-transfer; no ready is emitted.
- rdy=0: state, counter and all outputs freeze. Bus timing resumes unchanged when rdy returns to 1.
- Address arithmetic is base+k, modulo 2^32, with no alignment check.

Optional Feature:
Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, the port not served last wins (1-bit last-grant register, reset value = IF, so LS wins the first tie).
- Undefined: fixed LS priority as described above.
- clr masking and ready-cycle masking apply in both modes.

Test Plan:
- Reset, then if_req at 0x0000 with RAM bytes 13,00,00,00 → mem_a = 0,1,2,3 on T+1..T+4; if_ready at T+6; if_data=0x00000013.
- if_req and ls_req rise in the same cycle; load word at 0x100 holds 0xDEADBEEF → ls served first (ls_ready, ls_rdata=0xDEADBEEF), then fetch starts the cycle after ls_ready; with ROUND_ROBIN_EN a second tie goes to IF.
- Store half 0xABCD to 0x204 → T+1: mem_a=0x204, mem_dout=0xCD, mem_wr=1; T+2: mem_a=0x205, mem_dout=0xAB; ls_ready at T+3.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, one write of 0x41, then ls_ready; no duplicate write.
- Fetch in progress, clr pulsed at byte 2 → no if_ready; IDLE next cycle; new fetch to 0x80 completes with correct word.
- rdy low for 5 cycles mid load → mem_a, counter and outputs frozen; resumes with correct ls_rdata and total latency +5.
